// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encodings, error codes and the code-section
// marker byte, which is also used by the assembler-facing tooling.
// Pure declarations; no latency or backpressure of its own.
package program_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    LOADER_STATE_IDLE   = 3'd0,
    LOADER_STATE_LOAD   = 3'd1,
    LOADER_STATE_FINISH = 3'd2,
    LOADER_STATE_DONE   = 3'd3,
    LOADER_STATE_ERROR  = 3'd4
  } loader_state_t;

  // Values reported on the error port.
  localparam logic [1:0] LOADER_ERR_NONE       = 2'd0;
  localparam logic [1:0] LOADER_ERR_NO_MARKER  = 2'd1;
  localparam logic [1:0] LOADER_ERR_OVERFLOW   = 2'd2;
  localparam logic [1:0] LOADER_ERR_EMPTY_CODE = 2'd3;

  // Byte that ends the data section; code starts at the next address.
  localparam logic [7:0] LOADER_CODE_MARKER = 8'd14;

  // Outcome of a finished load, in priority order: an overflowed image is
  // always reported as overflow, then a missing marker, then a marker that
  // was the very last byte (code_start points one past the image).
  function automatic logic [1:0] loader_finish_code(
    input logic        overflow,
    input logic        found,
    input logic [31:0] code_start,
    input logic [31:0] byte_count
  );
    logic [1:0] code;
    code = LOADER_ERR_NONE;
    if (overflow)
      code = LOADER_ERR_OVERFLOW;
    else if (!found)
      code = LOADER_ERR_NO_MARKER;
    else if (code_start == byte_count)
      code = LOADER_ERR_EMPTY_CODE;
    return code;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: copies a byte-stream program image into RAM from address 0 and
// locates the code-section marker. Latency: RAM write 1 cycle after accept.
// Backpressure: in_ready is high only in LOAD; one byte per cycle sustained.
//
// Ports:
//   CLOCK_50                      system clock, rising edge
//   reset                         synchronous active-high reset
//   start                         one-cycle pulse, honoured in IDLE/DONE/ERROR
//   in_valid/in_data/in_last      image byte stream (in_last marks final byte)
//   in_ready                      byte accepted on edges with in_valid && in_ready
//   mem_we/mem_addr/mem_wdata     registered RAM write port
//   busy                          LOAD or FINISH
//   done                          image loaded with a usable code section
//   error                         none / no marker / overflow / empty code
//   code_start                    first instruction address (marker + 1)
//   byte_count                    bytes written so far
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 23,
  parameter int         MAX_BYTES   = 8000000,
  parameter logic [7:0] CODE_MARKER = LOADER_CODE_MARKER
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  output logic [31:0]           code_start,
  output logic [31:0]           byte_count
);

  localparam logic [31:0] LAST_INDEX = 32'(MAX_BYTES - 1);

  loader_state_t state, state_nxt;

  logic       found;       // first marker already seen in this image
  logic       overflow;    // RAM filled before in_last arrived
  logic       accept;
  logic       at_limit;    // the byte being offered would fill the last RAM slot
  logic [1:0] finish_code;

  assign accept      = in_valid && in_ready;
  assign at_limit    = (byte_count == LAST_INDEX);
  assign finish_code = loader_finish_code(overflow, found, code_start, byte_count);

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      state <= LOADER_STATE_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LOADER_STATE_IDLE,
      LOADER_STATE_DONE,
      LOADER_STATE_ERROR: begin
        if (start)
          state_nxt = LOADER_STATE_LOAD;
      end
      LOADER_STATE_LOAD: begin
        // Stop on the final byte, or on the byte that fills RAM.
        if (accept && (in_last || at_limit))
          state_nxt = LOADER_STATE_FINISH;
      end
      LOADER_STATE_FINISH: begin
        if (finish_code == LOADER_ERR_NONE)
          state_nxt = LOADER_STATE_DONE;
        else
          state_nxt = LOADER_STATE_ERROR;
      end
      default: state_nxt = LOADER_STATE_IDLE;
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      LOADER_STATE_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      LOADER_STATE_FINISH: begin
        busy = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Registered write port, counters and result flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      code_start <= '0;
      found      <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      error      <= LOADER_ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LOADER_STATE_IDLE,
        LOADER_STATE_DONE,
        LOADER_STATE_ERROR: begin
          // code_start is left alone; it is only meaningful once found is set.
          if (start) begin
            byte_count <= '0;
            found      <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            error      <= LOADER_ERR_NONE;
          end
        end
        LOADER_STATE_LOAD: begin
          if (accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= byte_count[ADDR_WIDTH-1:0];
            mem_wdata  <= in_data;
            byte_count <= byte_count + 32'd1;
            // Only the first marker splits the image; later ones are data.
            if (!found && (in_data == CODE_MARKER)) begin
              code_start <= byte_count + 32'd1;
              found      <= 1'b1;
            end
            if (at_limit && !in_last)
              overflow <= 1'b1;
          end
        end
        LOADER_STATE_FINISH: begin
          error <= finish_code;
          done  <= (finish_code == LOADER_ERR_NONE);
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed images from the test plan
// plus randomized images, compared against an image-level reference model.
// RAM is shrunk to 8 bytes so overflow is reachable with short streams.
module tb_program_loader;

  localparam int AW   = 23;
  localparam int MAXB = 8;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic [1:0]    error;
  logic [31:0]   code_start;
  logic [31:0]   byte_count;

  program_loader #(
    .ADDR_WIDTH (AW),
    .MAX_BYTES  (MAXB),
    .CODE_MARKER(8'd14)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .code_start(code_start),
    .byte_count(byte_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  img[$];
  int          wr_addr[$];
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];
  logic [31:0] model_cs = 0;

  always @(posedge CLOCK_50) cyc++;

  // Write monitor, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Start a load, stream img (optionally with gaps and stray start pulses),
  // then check the writes and final status against the image-level model.
  task automatic run_image(input string name, input bit gaps);
    int  n, mk, k, exp_err;
    bit  ovf, ended;
    n   = (img.size() > MAXB) ? MAXB : img.size();
    ovf = (img.size() > MAXB);
    mk  = -1;
    for (int i = 0; i < n; i++)
      if (img[i] == 8'h0E && mk < 0) mk = i;
    exp_err = ovf ? 2 : (mk < 0) ? 1 : (mk + 1 == n) ? 3 : 0;
    if (mk >= 0) model_cs = 32'(mk + 1);

    clear_writes();
    @(negedge CLOCK_50);
    start = 1'b1;
    k     = 0;
    ended = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLOCK_50);
      start = gaps && ($urandom_range(0, 3) == 0);   // must be ignored while busy
      if (!in_ready) begin
        ended = 1'b1;
        break;
      end
      if (k >= img.size() || (gaps && $urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = $urandom_range(0, 1) == 1;
      end else begin
        in_valid = 1'b1;
        in_data  = img[k];
        in_last  = (k == img.size() - 1);
      end
      @(posedge CLOCK_50);
      if (in_valid) k++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, " load_ended"}, 32'(ended), 32'd1);

    // FINISH: final byte being written, not yet done.
    check({name, " accepted"},     32'(k),      32'(n));
    check({name, " fin_in_ready"}, 32'(in_ready), 32'd0);
    check({name, " fin_busy"},     32'(busy),   32'd1);
    check({name, " fin_mem_we"},   32'(mem_we), 32'd1);
    check({name, " fin_done"},     32'(done),   32'd0);

    // DONE / ERROR.
    @(negedge CLOCK_50);
    check({name, " done"},       32'(done),     (exp_err == 0) ? 32'd1 : 32'd0);
    check({name, " error"},      32'(error),    32'(exp_err));
    check({name, " byte_count"}, byte_count,    32'(n));
    check({name, " code_start"}, code_start,    model_cs);
    check({name, " busy"},       32'(busy),     32'd0);
    check({name, " in_ready"},   32'(in_ready), 32'd0);

    // A stray byte offered after the load must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    check({name, " post_mem_we"}, 32'(mem_we), 32'd0);
    check({name, " post_count"},  byte_count,  32'(n));
    check({name, " post_error"},  32'(error),  32'(exp_err));

    check({name, " wr_count"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("%s wr_addr[%0d]", name, i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("%s wr_data[%0d]", name, i), 32'(wr_data[i]), 32'(img[i]));
      if (!gaps)
        check($sformatf("%s wr_cyc[%0d]", name, i), 32'(wr_cyc[i] - wr_cyc[0]), 32'(i));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " in_ready"},   32'(in_ready),  32'd0);
    check({name, " mem_we"},     32'(mem_we),    32'd0);
    check({name, " busy"},       32'(busy),      32'd0);
    check({name, " done"},       32'(done),      32'd0);
    check({name, " error"},      32'(error),     32'd0);
    check({name, " code_start"}, code_start,     32'd0);
    check({name, " byte_count"}, byte_count,     32'd0);
    check({name, " mem_addr"},   32'(mem_addr),  32'd0);
    check({name, " mem_wdata"},  32'(mem_wdata), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge CLOCK_50);

    img = '{8'h05, 8'h07, 8'h0E, 8'h01, 8'h00, 8'h00};
    run_image("basic", 1'b0);
    run_image("basic_gaps", 1'b1);

    img = '{8'h0E, 8'h02, 8'h0E, 8'h09};
    run_image("two_markers", 1'b0);

    img = '{8'h01, 8'h02, 8'h03};
    run_image("no_marker", 1'b0);

    img = '{8'h04, 8'h0E};
    run_image("marker_last", 1'b0);

    img = '{8'h0E};
    run_image("lone_marker", 1'b0);

    img = '{8'h10, 8'h0E, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run_image("overflow", 1'b0);

    img = '{8'h10, 8'h0E, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    run_image("exact_fit", 1'b0);

    // Reset in the middle of a load, with a byte on the bus.
    img = '{8'h21, 8'h0E, 8'h22, 8'h23, 8'h24};
    clear_writes();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      in_last  = 1'b0;
      @(negedge CLOCK_50);
    end
    in_data = img[3];
    reset   = 1'b1;
    @(negedge CLOCK_50);
    reset    = 1'b0;
    in_valid = 1'b0;
    model_cs = 0;
    check_all_zero("midreset");
    check("midreset wr_count", 32'(wr_addr.size()), 32'd3);
    run_image("after_reset", 1'b0);

    // Randomized images: short streams, marker-heavy, some overflowing.
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 10);
      img.delete();
      for (int i = 0; i < len; i++)
        img.push_back(($urandom_range(0, 3) == 0) ? 8'h0E : 8'($urandom));
      run_image($sformatf("rand%0d", t), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the CPU core.
- Accepts the compiled program image as a byte stream from the SD-card reader and writes it sequentially into main RAM from address 0.
- Locates the code-section marker byte and reports code_section_start_address, which the core loads into IP.
- Asserts done so the core can leave its load-to-RAM state and begin fetching.

Parameters:
- ADDR_WIDTH, 23, RAM byte-address width (8 MB space).
- MAX_BYTES, 8000000, RAM capacity in bytes; image must fit.
- CODE_MARKER, 8'd14, byte value that terminates the data section; code begins at the following address.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  stream byte available.
- in_data  in  8  stream byte.
- in_last  in  1  qualifies the final byte of the image.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  RAM write strobe, one cycle per byte.
- mem_addr  out  ADDR_WIDTH  RAM write address.
- mem_wdata  out  8  RAM write data.
- busy  out  1  load in progress (LOAD or FINISH).
- done  out  1  image loaded with a valid marker; level, held until the next start or reset.
- error  out  2  0 none, 1 no marker, 2 overflow, 3 marker is the final byte (empty code section); held with state.
- code_start  out  32  address of the first instruction byte (marker address + 1).
- byte_count  out  32  number of bytes written.

Behaviour:
- Reset, from any state including mid-load, takes effect on the next edge:
  - State goes to IDLE.
  - in_ready, mem_we, busy and done go to 0.
  - error, code_start, byte_count and mem_addr go to 0.
  - mem_wdata goes to 0; an in-flight byte is discarded.
- States: IDLE, LOAD, FINISH, DONE, ERROR.
- IDLE/DONE/ERROR + start=1 → LOAD.
  - Clears byte_count, the found flag, done and error.
- LOAD:
  - in_ready=1 combinationally.
  - A byte is accepted on an edge where in_valid && in_ready.
  - On acceptance, registered outputs become mem_we=1, mem_addr=byte_count[ADDR_WIDTH-1:0], mem_wdata=in_data; byte_count increments. Write latency is 1 cycle from acceptance.
  - mem_we=0 on any cycle with no acceptance.
  - Marker detection applies only to the first byte equal to CODE_MARKER: code_start <= byte_count+1 and found <= 1. Later marker bytes are plain data.
  - Accepted byte with in_last=1 → FINISH.
  - Accepted byte at byte_count==MAX_BYTES-1 with in_last=0 → FINISH with an overflow flag set. That byte is written; no further bytes are accepted.
- FINISH:
  - in_ready=0; mem_we is high here for the final byte.
  - Next edge goes to DONE or ERROR by priority: overflow → error=2; else !found → error=1; else code_start==byte_count → error=3; else DONE with done=1.
- DONE/ERROR: in_ready=0, mem_we=0, busy=0; outputs hold.
- start is ignored while busy.
- in_valid is ignored outside LOAD; the stream holds its byte until in_ready.
- in_last is meaningful only with in_valid.
- Back-to-back accepts sustain one byte per cycle.
- Minimum image is one byte; a lone marker gives error=3.
- byte_count never exceeds MAX_BYTES.

Decomposition:
- Shared defines file (alongside the existing state/opcode defines):
  - LOADER_STATE_IDLE/LOAD/FINISH/DONE/ERROR encodings.
  - LOADER_ERR_NONE/NO_MARKER/OVERFLOW/EMPTY_CODE codes.
  - CODE_MARKER value, shared with the assembler-facing constant.
- Single flat module.
- The optional stream-side skid buffer is not needed at one byte per cycle, so no sub-module.

Test Plan:
- Bytes 05,07,0E,01,00,00 (last on 00) with in_valid held high → six consecutive mem_we pulses at addresses 0..5 with matching data; code_start=3, byte_count=6; done=1 two cycles after the last accept; error=0.
- Same image with in_valid toggled every other cycle → identical writes (addresses contiguous, no duplicates); in_ready=0 in FINISH/DONE.
- Image 0E,02,0E,09 → code_start=1; the second 0E is written as data; done=1.
- Image 01,02,03 with no marker → error=1, done=0.
- Image 04,0E (marker last) → error=3.
- MAX_BYTES=8 and a 10-byte stream → writes 0..7 only, error=2, in_ready=0 after the 8th byte.
- reset asserted mid-load after 3 bytes → the next cycle shows IDLE, all outputs 0; a fresh start reloads from address 0.
